// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage (cpu_*) and the debug port (dbg_*).
// Ack arrives MEM_LAT+2 cycles after the sampling edge; requesters hold req until ack, and cpu_stall freezes the pipe meanwhile.
module dmem_port_arbiter #(
   parameter int DATA_W       = 64,
   parameter int ADDR_W       = 10,
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   localparam int LW = $clog2(MEM_LAT + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   state_t        state, state_nxt;
   cmd_t          sel_cmd;
   logic          grant, grant_dbg, done;
   logic          win_dbg, win_we;
   logic [LW-1:0] lat_cnt;
   logic [SW-1:0] dbg_wait;

   // cpu wins ties unless the debug port has waited long enough
   always_comb begin
      grant_dbg = dbg_req && (!cpu_req || (dbg_wait >= SW'(STARVE_LIMIT)));
      sel_cmd   = grant_dbg ? {dbg_we, dbg_addr, dbg_wdata} : {cpu_we, cpu_addr, cpu_wdata};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req || dbg_req) begin
               grant     = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (lat_cnt == LW'(1)) begin
               done      = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_dbg   <= 1'b0;
         win_we    <= 1'b0;
         lat_cnt   <= '0;
         dbg_wait  <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_ack   <= 1'b0;
         dbg_ack   <= 1'b0;
         cpu_rdata <= '0;
         dbg_rdata <= '0;
      end else begin
         mem_en  <= grant;
         cpu_ack <= done && !win_dbg;
         dbg_ack <= done && win_dbg;

         if (grant) begin
            win_dbg   <= grant_dbg;
            win_we    <= sel_cmd.we;
            mem_we    <= sel_cmd.we;
            mem_addr  <= sel_cmd.addr;
            mem_wdata <= sel_cmd.wdata;
         end

         if (state == ISSUE) begin
            lat_cnt <= LW'(MEM_LAT);
         end else if (state == WAIT) begin
            lat_cnt <= lat_cnt - 1'b1;
         end

         // stores complete with an ack but leave the requester's read data untouched
         if (done && !win_we) begin
            if (win_dbg) begin
               dbg_rdata <= mem_rdata;
            end else begin
               cpu_rdata <= mem_rdata;
            end
         end

         if (!dbg_req || (grant && grant_dbg)) begin
            dbg_wait <= '0;
         end else if (!(busy && win_dbg) && (dbg_wait < SW'(STARVE_LIMIT))) begin
            dbg_wait <= dbg_wait + 1'b1;
         end
      end
   end

   assign busy      = (state != IDLE);
   assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
